// File: rtl/matrix_burst_master_if.sv
// Slave register-decode and master write-port bundle for matrix_burst_master.
// The block uses the "master" modport; a bus model or bench uses "slave".
interface matrix_burst_master_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0] S_address;
   logic              S_sel;
   logic              S_wr;
   logic [DATA_W-1:0] S_din;
   logic [ADDR_W-1:0] M_address;
   logic [DATA_W-1:0] M_dout;
   logic              M_req;
   logic              M_wr;
   logic              M_grant;

   modport master (
      input  S_address, S_sel, S_wr, S_din, M_grant,
      output M_address, M_dout, M_req, M_wr
   );

   modport slave (
      output S_address, S_sel, S_wr, S_din, M_grant,
      input  M_address, M_dout, M_req, M_wr
   );
endinterface

// File: rtl/matrix_burst_master.sv
// Burst write master: on a qualified trigger, writes rData to len_reg consecutive
// addresses from DST_BASE, advancing one beat per granted cycle.
module matrix_burst_master #(
   parameter int                DATA_W      = 32,
   parameter int                ADDR_W      = 8,
   parameter int                MAX_WORDS   = 4,
   parameter logic [ADDR_W-1:0] DST_BASE    = 8'h60,
   parameter logic [3:0]        TRIG_OFFSET = 4'h6,
   parameter logic [3:0]        LEN_OFFSET  = 4'h7
) (
   input  logic                   clk,
   input  logic                   reset_n,
   matrix_burst_master_if.master  bus,
   input  logic                   clear,
   input  logic                   m_interrupt,
   input  logic [DATA_W-1:0]      rData,
   output logic                   busy,
   output logic                   done
);
   localparam int LEN_W = $clog2(MAX_WORDS + 1);

   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d, len_q, len_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              req_q, req_d, busy_q, busy_d, done_q, done_d;
   logic              sel_wr, trig, len_wr, last_beat;

   // Only the low nibble of the slave address is decoded.
   wire unused_addr_hi = &{1'b0, bus.S_address[ADDR_W-1:4]};

   assign sel_wr    = bus.S_sel && bus.S_wr;
   assign trig      = sel_wr && (bus.S_address[3:0] == TRIG_OFFSET) && m_interrupt;
   assign len_wr    = sel_wr && (bus.S_address[3:0] == LEN_OFFSET);
   assign last_beat = (cnt_q == len_q - LEN_W'(1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      req_d   = req_q;
      len_d   = len_q;

      // The clamp looks at the whole write value so e.g. 9 is "too long", not 9 mod 8.
      if (len_wr && state_q != XFER) begin
         if (bus.S_din == '0 || bus.S_din > DATA_W'(MAX_WORDS))
            len_d = LEN_W'(MAX_WORDS);
         else
            len_d = bus.S_din[LEN_W-1:0];
      end

      case (state_q)
         IDLE: begin
            if (trig) begin
               state_d = XFER;
               cnt_d   = '0;
               addr_d  = DST_BASE;
               req_d   = 1'b1;
            end
         end
         XFER: begin
            if (bus.M_grant) begin
               if (last_beat) begin
                  state_d = DONE;
                  cnt_d   = '0;
                  addr_d  = '0;
                  req_d   = 1'b0;
               end else begin
                  cnt_d  = cnt_q + LEN_W'(1);
                  addr_d = addr_q + ADDR_W'(1);
               end
            end
         end
         DONE:    ;
         default: state_d = IDLE;
      endcase

      // Abort wins over trigger and over a completing beat; len_reg survives it.
      if (clear) begin
         state_d = IDLE;
         cnt_d   = '0;
         addr_d  = '0;
         req_d   = 1'b0;
      end

      busy_d = (state_d == XFER);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         len_q   <= LEN_W'(MAX_WORDS);
         addr_q  <= '0;
         req_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         addr_q  <= addr_d;
         req_q   <= req_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.M_address = addr_q;
   assign bus.M_req     = req_q;
   assign bus.M_wr      = req_q;
   assign bus.M_dout    = req_q ? rData : '0;
   assign busy          = busy_q;
   assign done          = done_q;
endmodule

// File: tb/tb_matrix_burst_master.sv
// Directed bench for matrix_burst_master: a queue-of-beats model checked every
// cycle on two instances (base 8'h60 and 8'hFE) plus literal spot checks.
module tb_matrix_burst_master;
   localparam int MAXW = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        clear;
   logic        m_interrupt;
   logic [31:0] rData;
   logic        busy, done, busy2, done2;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   matrix_burst_master_if #(.DATA_W(32), .ADDR_W(8)) bus ();
   matrix_burst_master_if #(.DATA_W(32), .ADDR_W(8)) bus2 ();

   assign bus2.S_address = bus.S_address;
   assign bus2.S_sel     = bus.S_sel;
   assign bus2.S_wr      = bus.S_wr;
   assign bus2.S_din     = bus.S_din;
   assign bus2.M_grant   = bus.M_grant;

   matrix_burst_master #(.DATA_W(32), .ADDR_W(8), .MAX_WORDS(MAXW), .DST_BASE(8'h60)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus), .clear(clear),
      .m_interrupt(m_interrupt), .rData(rData), .busy(busy), .done(done)
   );

   matrix_burst_master #(.DATA_W(32), .ADDR_W(8), .MAX_WORDS(MAXW), .DST_BASE(8'hFE)) dut2 (
      .clk(clk), .reset_n(reset_n), .bus(bus2), .clear(clear),
      .m_interrupt(m_interrupt), .rData(rData), .busy(busy2), .done(done2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
      end
   endtask

   // Model: outstanding beats are a queue of offsets from the base address.
   int q[$];
   bit done_m = 1'b0;
   int len_m  = MAXW;

   always @(posedge clk) begin
      if (!reset_n) begin
         q.delete();
         done_m = 1'b0;
         len_m  = MAXW;
      end else begin
         if (q.size() == 0 && bus.S_sel && bus.S_wr && bus.S_address[3:0] == 4'h7)
            len_m = (bus.S_din == 0 || bus.S_din > MAXW) ? MAXW : int'(bus.S_din);
         if (clear) begin
            q.delete();
            done_m = 1'b0;
         end else if (q.size() != 0) begin
            if (bus.M_grant) begin
               void'(q.pop_front());
               if (q.size() == 0) done_m = 1'b1;
            end
         end else if (!done_m && bus.S_sel && bus.S_wr && bus.S_address[3:0] == 4'h6 && m_interrupt) begin
            for (int i = 0; i < len_m; i++) q.push_back(i);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         logic        r;
         logic [7:0]  a1, a2;
         r  = (q.size() != 0);
         a1 = r ? 8'(32'h60 + q[0]) : 8'h00;
         a2 = r ? 8'(32'hFE + q[0]) : 8'h00;
         chk("m_req",   {31'b0, bus.M_req},  {31'b0, r});
         chk("m_wr",    {31'b0, bus.M_wr},   {31'b0, r});
         chk("m_addr",  {24'b0, bus.M_address}, {24'b0, a1});
         chk("m_dout",  bus.M_dout, r ? rData : 32'h0);
         chk("busy",    {31'b0, busy}, {31'b0, r});
         chk("done",    {31'b0, done}, {31'b0, done_m});
         chk("m_req2",  {31'b0, bus2.M_req}, {31'b0, r});
         chk("m_addr2", {24'b0, bus2.M_address}, {24'b0, a2});
         chk("done2",   {31'b0, done2}, {31'b0, done_m});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      rData = $urandom();
   endtask

   task automatic idle_bus();
      bus.S_sel     = 1'b0;
      bus.S_wr      = 1'b0;
      bus.S_address = 8'h00;
      bus.S_din     = 32'h0;
   endtask

   task automatic slave_wr(input logic [7:0] a, input logic [31:0] d);
      bus.S_sel     = 1'b1;
      bus.S_wr      = 1'b1;
      bus.S_address = a;
      bus.S_din     = d;
   endtask

   task automatic wr_len(input logic [31:0] d);
      slave_wr(8'h07, d);
      tick();
      idle_bus();
   endtask

   task automatic trig();
      slave_wr(8'h06, 32'h0);
      m_interrupt = 1'b1;
      tick();
      idle_bus();
      m_interrupt = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   // Counts request cycles of one burst; optional stall window, length write, clear.
   task automatic burst(input int stall_at, input int stall_n, input int lenwr_at,
                        input int clr_at, output int reqs, output int hold61);
      trig();
      reqs   = 0;
      hold61 = 0;
      while (bus.M_req && reqs < 60) begin
         reqs++;
         if (bus.M_address == 8'h61) hold61++;
         bus.M_grant = !(reqs >= stall_at && reqs < stall_at + stall_n);
         if (reqs == lenwr_at) slave_wr(8'h07, 32'd3);
         clear = (reqs == clr_at);
         tick();
         idle_bus();
         clear       = 1'b0;
         bus.M_grant = 1'b1;
      end
      chk("burst_bound", {31'b0, reqs < 60}, 32'd1);
   endtask

   initial begin
      int reqs, hold;
      reset_n     = 1'b0;
      clear       = 1'b0;
      m_interrupt = 1'b0;
      rData       = 32'h0;
      bus.M_grant = 1'b1;
      idle_bus();
      tick();
      chk_en = 1'b1;
      tick();
      chk("rst_req",  {31'b0, bus.M_req}, 32'd0);
      chk("rst_addr", {24'b0, bus.M_address}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      reset_n = 1'b1;
      tick();

      // Default-length burst, grant tied high.
      trig();
      chk("b1_a0",  {24'b0, bus.M_address}, 32'h60);
      chk("b1_f0",  {24'b0, bus2.M_address}, 32'hFE);
      tick();
      chk("b1_a1",  {24'b0, bus.M_address}, 32'h61);
      chk("b1_f1",  {24'b0, bus2.M_address}, 32'hFF);
      tick();
      chk("b1_a2",  {24'b0, bus.M_address}, 32'h62);
      chk("b1_f2",  {24'b0, bus2.M_address}, 32'h00);
      tick();
      chk("b1_a3",  {24'b0, bus.M_address}, 32'h63);
      chk("b1_f3",  {24'b0, bus2.M_address}, 32'h01);
      chk("b1_wr",  {31'b0, bus.M_wr}, 32'd1);
      tick();
      chk("b1_done", {31'b0, done}, 32'd1);
      chk("b1_req",  {31'b0, bus.M_req}, 32'd0);
      do_clear();
      chk("b1_clr",  {31'b0, done}, 32'd0);

      // Trigger without source-ready is ignored.
      slave_wr(8'h06, 32'h0);
      tick();
      idle_bus();
      chk("no_irq", {31'b0, bus.M_req}, 32'd0);

      // Length 2.
      wr_len(32'd2);
      burst(0, 0, 0, 0, reqs, hold);
      chk("len2_beats", reqs, 32'd2);
      do_clear();

      // Stall three cycles on the second beat.
      wr_len(32'd4);
      burst(2, 3, 0, 0, reqs, hold);
      chk("stall_reqs", reqs, 32'd7);
      chk("stall_hold", hold, 32'd4);
      do_clear();

      // Out-of-range lengths clamp; length write during XFER ignored.
      wr_len(32'd0);
      burst(0, 0, 0, 0, reqs, hold);
      chk("len0_beats", reqs, 32'd4);
      do_clear();
      wr_len(32'd9);
      burst(0, 0, 2, 0, reqs, hold);
      chk("len9_beats", reqs, 32'd4);
      do_clear();
      burst(0, 0, 0, 0, reqs, hold);
      chk("len_keep", reqs, 32'd4);
      do_clear();

      // Clear with the third beat.
      burst(0, 0, 0, 3, reqs, hold);
      chk("clr_reqs", reqs, 32'd3);
      chk("clr_addr", {24'b0, bus.M_address}, 32'd0);
      chk("clr_done", {31'b0, done}, 32'd0);

      // Trigger and clear together in IDLE.
      slave_wr(8'h06, 32'h0);
      m_interrupt = 1'b1;
      clear       = 1'b1;
      tick();
      idle_bus();
      m_interrupt = 1'b0;
      clear       = 1'b0;
      chk("trgclr_busy", {31'b0, busy}, 32'd0);
      tick();
      chk("trgclr_req",  {31'b0, bus.M_req}, 32'd0);

      // Reset mid-burst; length returns to MAX_WORDS.
      wr_len(32'd2);
      trig();
      tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      chk("mrst_req",  {31'b0, bus.M_req}, 32'd0);
      chk("mrst_addr", {24'b0, bus.M_address}, 32'd0);
      chk("mrst_busy", {31'b0, busy}, 32'd0);
      tick();
      burst(0, 0, 0, 0, reqs, hold);
      chk("mrst_len", reqs, 32'd4);
      tick();

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
